// File: rtl/legv8_datapath_jd_if.sv
// Bus bundle between a LEGv8 controller and the datapath: control word and
// immediate in, shared data bus, address, flags and debug taps out.
interface legv8_datapath_jd_if;
   logic [39:0] ControlWord;
   logic [63:0] constant;
   logic [63:0] data;
   logic [31:0] address;
   logic [4:0]  status;
   logic [31:0] IR_out;
   logic [3:0]  current_status;
   logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;

   // controller side: drives the control word and immediate
   modport master (
      output ControlWord, constant,
      input  data, address, status, IR_out, current_status,
      input  r0, r1, r2, r3, r4, r5, r6, r7
   );

   // datapath side
   modport slave (
      input  ControlWord, constant,
      output data, address, status, IR_out, current_status,
      output r0, r1, r2, r3, r4, r5, r6, r7
   );
endinterface

// File: rtl/legv8_datapath_jd.sv
// 64-bit LEGv8 datapath steered by a 40-bit control word each cycle:
// register file, ALU with B-operand mux, data RAM, PC, IR and NZCV register,
// all loading from one shared data bus.
module legv8_datapath_jd #(
   parameter int RAM_WORDS = 256
) (
   input logic                clock,
   input logic                reset,
   legv8_datapath_jd_if.slave bus
);
   localparam int AW = $clog2(RAM_WORDS);

   typedef struct packed {
      logic [5:0] rsvd_hi;
      logic       pc_en;
      logic [1:0] bs;
      logic [1:0] ps;
      logic       as_pc;
      logic       bsel;
      logic       ir_load;
      logic       sl;
      logic [4:0] fs;
      logic       c0;
      logic [1:0] rsvd_lo;
      logic       mw;
      logic       rw;
      logic [4:0] da;
      logic [4:0] sa;
      logic [4:0] sb;
   } cw_t;

   cw_t         cw;
   logic [63:0] xreg [0:31];
   logic [63:0] ram  [0:RAM_WORDS-1];
   logic [63:0] pc;
   logic [31:0] ir;
   logic [3:0]  nzcv_q;
   logic [63:0] a_val, breg, b_val, a_op, b_op, alu_y, dbus, ram_rd;
   logic [64:0] add_y;
   logic        is_add, flag_z, flag_n, flag_c, flag_v, flag_za;
   logic [31:0] addr;
   logic [AW-1:0] ram_idx;
   logic        unused_ok;

   assign cw        = bus.ControlWord;
   assign unused_ok = ^{cw.rsvd_hi, cw.rsvd_lo};

   // X31 is the zero register: never written, always read as 0
   assign a_val = (cw.sa == 5'd31) ? '0 : xreg[cw.sa];
   assign breg  = (cw.sb == 5'd31) ? '0 : xreg[cw.sb];
   assign b_val = cw.bsel ? bus.constant : breg;
   assign a_op  = cw.fs[1] ? ~a_val : a_val;
   assign b_op  = cw.fs[0] ? ~b_val : b_val;
   assign add_y = {1'b0, a_op} + {1'b0, b_op} + {64'd0, cw.c0};
   assign is_add = (cw.fs[4:2] == 3'b010);

   // ALU function select; shifts and pass-through use the uninverted operands
   always_comb begin
      alu_y = '0;
      case (cw.fs[4:2])
         3'b000: alu_y = a_op & b_op;
         3'b001: alu_y = a_op | b_op;
         3'b010: alu_y = add_y[63:0];
         3'b011: alu_y = a_op ^ b_op;
         3'b100: alu_y = a_val << b_val[5:0];
         3'b101: alu_y = a_val >> b_val[5:0];
         3'b110: alu_y = b_val;
         default: alu_y = '0;
      endcase
   end

   assign flag_z  = (alu_y == '0);
   assign flag_n  = alu_y[63];
   assign flag_c  = is_add & add_y[64];
   assign flag_v  = is_add & (a_op[63] == b_op[63]) & (add_y[63] != a_op[63]);
   assign flag_za = (a_val == '0);

   assign addr    = cw.as_pc ? pc[31:0] : alu_y[31:0];
   assign ram_idx = addr[3 +: AW];
   assign ram_rd  = ram[ram_idx];

   // shared bus source select
   always_comb begin
      dbus = alu_y;
      case (cw.bs)
         2'b00: dbus = alu_y;
         2'b01: dbus = breg;
         2'b10: dbus = pc + 64'd4;
         2'b11: dbus = ram_rd;
         default: dbus = alu_y;
      endcase
   end

   // register file writeback from the bus
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++) xreg[i] <= '0;
      end else if (cw.rw && (cw.da != 5'd31)) begin
         xreg[cw.da] <= dbus;
      end
   end

   // data RAM write; contents deliberately survive reset
   always_ff @(posedge clock) begin
      if (cw.mw) ram[ram_idx] <= dbus;
   end

   // program counter update
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pc <= '0;
      end else if (cw.pc_en) begin
         case (cw.ps)
            2'b01:   pc <= pc + 64'd4;
            2'b10:   pc <= a_val;
            2'b11:   pc <= pc + {b_val[61:0], 2'b00};
            default: pc <= pc;
         endcase
      end
   end

   // instruction register and registered NZCV
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ir     <= '0;
         nzcv_q <= '0;
      end else begin
         if (cw.ir_load) ir     <= dbus[31:0];
         if (cw.sl)      nzcv_q <= {flag_v, flag_c, flag_n, flag_z};
      end
   end

   assign bus.data           = dbus;
   assign bus.address        = addr;
   assign bus.status         = {flag_za, flag_v, flag_c, flag_n, flag_z};
   assign bus.IR_out         = ir;
   assign bus.current_status = nzcv_q;
   assign bus.r0 = xreg[0][15:0];
   assign bus.r1 = xreg[1][15:0];
   assign bus.r2 = xreg[2][15:0];
   assign bus.r3 = xreg[3][15:0];
   assign bus.r4 = xreg[4][15:0];
   assign bus.r5 = xreg[5][15:0];
   assign bus.r6 = xreg[6][15:0];
   assign bus.r7 = xreg[7][15:0];
endmodule

// File: tb/tb_legv8_datapath_jd.sv
// Bench for legv8_datapath_jd: directed walk through the datapath features,
// then randomized control words checked against an arithmetic reference model.
module tb_legv8_datapath_jd;
   logic clock = 1'b0;
   logic reset = 1'b0;

   legv8_datapath_jd_if bus ();
   legv8_datapath_jd dut (.clock(clock), .reset(reset), .bus(bus));

   always #5 clock = ~clock;

   int checks = 0;
   int passed = 0;
   int fails  = 0;

   // reference state
   logic [63:0] mx [0:31];
   logic [63:0] mem [int];
   logic [63:0] m_pc;
   logic [31:0] m_ir;
   logic [3:0]  m_cs;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [39:0] mkcw(input logic pcen, input logic [1:0] bs, input logic [1:0] ps,
                                         input logic as_, input logic bsel, input logic irl, input logic sl,
                                         input logic [4:0] fs, input logic c0, input logic mw, input logic rw,
                                         input logic [4:0] da, input logic [4:0] sa, input logic [4:0] sb);
      return {6'b0, pcen, bs, ps, as_, bsel, irl, sl, fs, c0, 2'b0, mw, rw, da, sa, sb};
   endfunction

   function automatic logic [63:0] rd(input logic [4:0] i);
      return (i == 5'd31) ? 64'd0 : mx[i];
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'((a / 32'd8) % 32'd256);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) mx[i] = 64'd0;
      m_pc = 64'd0;
      m_ir = 32'd0;
      m_cs = 4'd0;
   endtask

   // combinational view of one cycle, straight from the arithmetic definitions
   task automatic model_eval(input logic [39:0] w, input logic [63:0] k,
                             output logic [4:0] st, output logic [31:0] adr,
                             output logic [63:0] d, output logic [63:0] av, output logic [63:0] bv);
      logic [4:0] fs;
      logic [63:0] ap, bp, res;
      logic c, v;
      logic [65:0] u;
      logic signed [65:0] s, rs;
      fs = w[24:20];
      av = rd(w[9:5]);
      bv = w[27] ? k : rd(w[4:0]);
      ap = fs[1] ? ~av : av;
      bp = fs[0] ? ~bv : bv;
      c = 1'b0;
      v = 1'b0;
      res = 64'd0;
      case (fs[4:2])
         3'd0: res = ap & bp;
         3'd1: res = ap | bp;
         3'd2: begin
            u   = 66'(ap) + 66'(bp) + 66'(w[19]);
            res = u[63:0];
            c   = (u >= 66'h1_0000_0000_0000_0000);
            s   = 66'($signed(ap)) + 66'($signed(bp)) + 66'(w[19]);
            rs  = 66'($signed(res));
            v   = (s != rs);
         end
         3'd3: res = ap ^ bp;
         3'd4: res = av << bv[5:0];
         3'd5: res = av >> bv[5:0];
         3'd6: res = bv;
         default: res = 64'd0;
      endcase
      st  = {av == 64'd0, v, c, res[63], res == 64'd0};
      adr = w[28] ? m_pc[31:0] : res[31:0];
      case (w[32:31])
         2'd0: d = res;
         2'd1: d = rd(w[4:0]);
         2'd2: d = m_pc + 64'd4;
         default: d = mem.exists(widx(adr)) ? mem[widx(adr)] : 64'hx;
      endcase
   endtask

   task automatic model_commit(input logic [39:0] w, input logic [4:0] st, input logic [31:0] adr,
                               input logic [63:0] d, input logic [63:0] av, input logic [63:0] bv);
      if (w[15] && w[14:10] != 5'd31) mx[w[14:10]] = d;
      if (w[16]) mem[widx(adr)] = d;
      if (w[26]) m_ir = d[31:0];
      if (w[25]) m_cs = st[3:0];
      if (w[33]) begin
         case (w[30:29])
            2'd1: m_pc = m_pc + 64'd4;
            2'd2: m_pc = av;
            2'd3: m_pc = m_pc + bv * 64'd4;
            default: m_pc = m_pc;
         endcase
      end
   endtask

   // one clock: entered just after a rising edge, leaves just after the next
   task automatic cyc(input logic [39:0] w, input logic [63:0] k);
      logic [4:0] st;
      logic [31:0] adr;
      logic [63:0] d, av, bv;
      logic [15:0] rv [8];
      bus.ControlWord = w;
      bus.constant    = k;
      model_eval(w, k, st, adr, d, av, bv);
      @(negedge clock);
      chk("status", 64'(bus.status), 64'(st));
      chk("address", 64'(bus.address), 64'(adr));
      chk("data", bus.data, d);
      @(posedge clock);
      model_commit(w, st, adr, d, av, bv);
      #1;
      chk("IR_out", 64'(bus.IR_out), 64'(m_ir));
      chk("current_status", 64'(bus.current_status), 64'(m_cs));
      rv = '{bus.r0, bus.r1, bus.r2, bus.r3, bus.r4, bus.r5, bus.r6, bus.r7};
      for (int i = 0; i < 8; i++) chk($sformatf("r%0d", i), 64'(rv[i]), 64'(mx[i][15:0]));
   endtask

   task automatic chk_reset_state();
      logic [15:0] rv [8];
      chk("rst_IR", 64'(bus.IR_out), 64'd0);
      chk("rst_cs", 64'(bus.current_status), 64'd0);
      chk("rst_pc", 64'(bus.address), 64'd0);
      rv = '{bus.r0, bus.r1, bus.r2, bus.r3, bus.r4, bus.r5, bus.r6, bus.r7};
      for (int i = 0; i < 8; i++) chk($sformatf("rst_r%0d", i), 64'(rv[i]), 64'd0);
   endtask

   initial begin
      logic [39:0] w;
      logic [63:0] k;
      logic [4:0] st;
      logic [31:0] adr;
      logic [63:0] d, av, bv;

      // power-up reset, address shows PC
      model_reset();
      bus.ControlWord = mkcw(0, 2'b00, 2'b00, 1, 0, 0, 0, 5'b00000, 0, 0, 0, 0, 0, 0);
      bus.constant    = 64'd0;
      repeat (2) @(posedge clock);
      #1 chk_reset_state();
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;

      // load immediate 24 into X0
      cyc(mkcw(0, 2'b00, 2'b00, 0, 1, 0, 0, 5'b00100, 0, 0, 1, 0, 31, 0), 64'd24);
      chk("li_r0", 64'(bus.r0), 64'h0018);

      // X1 = 0 - X0
      w = mkcw(0, 2'b00, 2'b00, 0, 0, 0, 0, 5'b01001, 1, 0, 1, 1, 31, 0);
      bus.ControlWord = w;
      bus.constant    = 64'h8000_0018;
      #1 chk("sub_CNZ", 64'(bus.status[2:0]), 64'(3'b010));
      cyc(w, 64'h8000_0018);
      chk("sub_r1", 64'(bus.r1), 64'hFFE8);

      // store X1 to address 0x80000018 (word 3)
      w = mkcw(0, 2'b01, 2'b00, 0, 1, 0, 0, 5'b01000, 0, 1, 0, 0, 31, 1);
      bus.ControlWord = w;
      bus.constant    = 64'h8000_0018;
      #1;
      chk("st_addr", 64'(bus.address), 64'h8000_0018);
      chk("st_data", bus.data, 64'hFFFF_FFFF_FFFF_FFE8);
      cyc(w, 64'h8000_0018);

      // X1 = X0 & X1
      cyc(mkcw(0, 2'b00, 2'b00, 0, 0, 0, 0, 5'b00000, 0, 0, 1, 1, 0, 1), 64'd0);
      chk("and_r1", 64'(bus.r1), 64'd8);

      // load word 3 into X2
      cyc(mkcw(0, 2'b11, 2'b00, 0, 1, 0, 0, 5'b01000, 0, 0, 1, 2, 31, 1), 64'h8000_0018);
      chk("ld_r2", 64'(bus.r2), 64'hFFE8);

      // IR from X1
      cyc(mkcw(0, 2'b01, 2'b00, 0, 0, 1, 0, 5'b00000, 0, 0, 0, 0, 0, 1), 64'd0);
      chk("ir", 64'(bus.IR_out), 64'h8);

      // PC sequence
      w = mkcw(1, 2'b00, 2'b00, 1, 0, 0, 0, 5'b00000, 0, 0, 0, 0, 0, 0);
      bus.ControlWord = w;
      #1 chk("pc_hold_pre", 64'(bus.address), 64'd0);
      cyc(w, 64'd0);
      chk("pc_hold", 64'(bus.address), 64'd0);
      cyc(mkcw(1, 2'b00, 2'b01, 1, 0, 0, 0, 5'b00000, 0, 0, 0, 0, 0, 0), 64'd0);
      chk("pc_inc", 64'(bus.address), 64'd4);
      cyc(mkcw(1, 2'b00, 2'b10, 1, 0, 0, 0, 5'b00000, 0, 0, 0, 0, 1, 0), 64'd0);
      chk("pc_jmpA", 64'(bus.address), 64'd8);
      cyc(mkcw(1, 2'b00, 2'b11, 1, 1, 0, 0, 5'b00000, 0, 0, 0, 0, 0, 0), 64'd1);
      chk("pc_rel", 64'(bus.address), 64'hC);

      // status register: equal subtract then hold
      cyc(mkcw(0, 2'b00, 2'b00, 0, 0, 0, 1, 5'b01001, 1, 0, 0, 0, 1, 1), 64'd0);
      chk("sl_cs", 64'(bus.current_status), 64'(4'b0101));
      cyc(mkcw(0, 2'b00, 2'b00, 0, 1, 0, 0, 5'b00100, 0, 0, 0, 0, 1, 0), 64'h8000_0000_0000_0000);
      chk("sl_hold", 64'(bus.current_status), 64'(4'b0101));

      // X31 write is dropped and reads zero
      cyc(mkcw(0, 2'b00, 2'b00, 0, 1, 0, 0, 5'b00110, 0, 0, 1, 31, 0, 0), 64'd77);
      w = mkcw(0, 2'b01, 2'b00, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 0, 0, 31);
      bus.ControlWord = w;
      #1 chk("x31_zero", bus.data, 64'd0);
      cyc(w, 64'd0);

      // mid-run asynchronous reset, held across an edge with a write pending
      bus.ControlWord = mkcw(0, 2'b00, 2'b00, 1, 1, 0, 0, 5'b00110, 0, 0, 1, 0, 0, 0);
      bus.constant    = 64'd5;
      reset = 1'b0;
      #1;
      model_reset();
      chk_reset_state();
      @(posedge clock);
      #1 chk("rst_hold_r0", 64'(bus.r0), 64'd0);
      @(negedge clock);
      reset = 1'b1;
      bus.ControlWord = 40'd0;
      @(posedge clock);
      #1;

      // randomized control words
      for (int n = 0; n < 300; n++) begin
         w = 40'({8'($urandom_range(255, 0)), $urandom});
         if ($urandom_range(1, 0) == 0) k = 64'($urandom_range(7, 0) * 8);
         else k = {$urandom, $urandom};
         model_eval(w, k, st, adr, d, av, bv);
         if (w[32:31] == 2'b11 && !mem.exists(widx(adr))) w[32:31] = 2'b00;
         cyc(w, k);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
